// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin merge of NREQ register-file write
// requesters onto one registered write port with an x0-filtered counter.
module rf_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NREQ       = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       hold,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic [ADDR_WIDTH-1:0]      rf_a3,
  output logic [DATA_WIDTH-1:0]      rf_wd3,
  output logic                       rf_we3,
  output logic [1:0]                 grant_id,
  output logic [15:0]                wr_count
);

  logic [1:0]            ptr;
  logic [1:0]            ptr_nxt;
  logic [1:0]            gidx;
  logic                  found;
  logic                  xfer;
  logic [2*NREQ-1:0]     rot;
  logic [2:0]            j3;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // Rotate valids so bit k is requester (ptr+k) mod NREQ; pick lowest.
  always_comb begin
    rot   = {req_valid, req_valid} >> ptr;
    found = 1'b0;
    gidx  = '0;
    j3    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        j3    = {1'b0, ptr} + 3'(k);
        if (j3 >= 3'(NREQ)) j3 = j3 - 3'(NREQ);
        gidx  = j3[1:0];
      end
    end
  end

  // Grant decode, write-operand mux and next priority pointer.
  always_comb begin
    xfer      = found && !hold && !reset;
    req_ready = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gidx == 2'(i)) begin
        req_ready[i] = xfer;
        sel_addr     = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    ptr_nxt = (gidx == 2'(NREQ-1)) ? 2'd0 : gidx + 2'd1;
  end

  // Write-port registers; writes to x0 are consumed but not enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr      <= '0;
      rf_we3   <= 1'b0;
      rf_a3    <= '0;
      rf_wd3   <= '0;
      grant_id <= '0;
      wr_count <= '0;
    end else begin
      rf_we3 <= 1'b0;
      if (xfer) begin
        ptr      <= ptr_nxt;
        rf_a3    <= sel_addr;
        rf_wd3   <= sel_data;
        grant_id <= gidx;
        rf_we3   <= (sel_addr != '0);
        if (sel_addr != '0) wr_count <= wr_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: scoreboard bench for the round-robin
// register-file write arbiter.
module tb_rf_write_arbiter;

  logic        clk;
  logic        reset;
  logic        hold;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;
  logic        rf_we3;
  logic [1:0]  grant_id;
  logic [15:0] wr_count;

  typedef struct packed {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
    logic [1:0]  id;
    logic [15:0] cnt;
  } exp_t;

  exp_t  q[$];
  exp_t  e;
  int    n_vec;
  int    n_err;
  int    m_ptr;
  logic [4:0]  m_a;
  logic [31:0] m_d;
  logic [1:0]  m_id;
  logic [15:0] m_cnt;
  logic [2:0]  er;

  rf_write_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .hold      (hold),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_a3     (rf_a3),
    .rf_wd3    (rf_wd3),
    .rf_we3    (rf_we3),
    .grant_id  (grant_id),
    .wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus and push the predicted write-port state.
  task automatic drive(input logic h, input logic [2:0] v,
                       input logic [14:0] a, input logic [95:0] d,
                       output logic [2:0] rdy);
    exp_t x;
    int   g;
    hold      = h;
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    g   = -1;
    rdy = '0;
    if (!h && !reset) begin
      for (int k = 0; k < 3; k++) begin
        int j;
        j = (m_ptr + k) % 3;
        if (g < 0 && v[j]) g = j;
      end
    end
    x.we = 1'b0;
    if (g >= 0) begin
      rdy[g] = 1'b1;
      m_a    = a[g*5 +: 5];
      m_d    = d[g*32 +: 32];
      m_id   = g[1:0];
      x.we   = (m_a != 5'd0);
      if (x.we) m_cnt = m_cnt + 16'd1;
      m_ptr  = (g + 1) % 3;
    end
    x.a   = m_a;
    x.d   = m_d;
    x.id  = m_id;
    x.cnt = m_cnt;
    q.push_back(x);
  endtask

  task automatic model_clear();
    m_ptr = 0;
    m_a   = '0;
    m_d   = '0;
    m_id  = '0;
    m_cnt = '0;
    q.delete();
  endtask

  task automatic test_reset();
    req_valid = 3'b111;
    #1;
    n_vec++;
    if ({req_ready, rf_we3, rf_a3, rf_wd3, grant_id, wr_count} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got rdy=%b we=%b a=%h wd=%h id=%0d cnt=%h want all 0",
               req_ready, rf_we3, rf_a3, rf_wd3, grant_id, wr_count);
    end
    @(negedge clk);
    reset     = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single();
    drive(1'b0, 3'b001, {5'd0, 5'd0, 5'd5}, {64'd0, 32'hDEADBEEF}, er);
    #1;
    n_vec++;
    if (req_ready !== er) begin
      n_err++;
      $display("FAIL single_ready: got %b want %b", req_ready, er);
    end
    @(negedge clk);
    e = q.pop_front();
    n_vec++;
    if ({rf_we3, rf_a3, rf_wd3, grant_id, wr_count} !== e) begin
      n_err++;
      $display("FAIL single_write: got %h want %h",
               {rf_we3, rf_a3, rf_wd3, grant_id, wr_count}, e);
    end
  endtask

  task automatic test_round_robin();
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 3'b111, {5'd3, 5'd2, 5'd1},
            {32'hC0 + 32'(c), 32'hB0 + 32'(c), 32'hA0 + 32'(c)}, er);
      #1;
      n_vec++;
      if (req_ready !== er) begin
        n_err++;
        $display("FAIL rr_ready[%0d]: got %b want %b", c, req_ready, er);
      end
      @(negedge clk);
      e = q.pop_front();
      n_vec++;
      if ({rf_we3, rf_a3, rf_wd3, grant_id, wr_count} !== e) begin
        n_err++;
        $display("FAIL rr_write[%0d]: got %h want %h", c,
                 {rf_we3, rf_a3, rf_wd3, grant_id, wr_count}, e);
      end
    end
  endtask

  task automatic test_x0();
    drive(1'b0, 3'b010, {5'd7, 5'd0, 5'd7}, {32'h1, 32'h1234, 32'h1}, er);
    #1;
    n_vec++;
    if (req_ready !== 3'b010) begin
      n_err++;
      $display("FAIL x0_ready: got %b want %b", req_ready, 3'b010);
    end
    @(negedge clk);
    e = q.pop_front();
    n_vec++;
    if ({rf_we3, rf_a3, rf_wd3, grant_id, wr_count} !== e) begin
      n_err++;
      $display("FAIL x0_write: got %h want %h",
               {rf_we3, rf_a3, rf_wd3, grant_id, wr_count}, e);
    end
  endtask

  task automatic test_hold();
    for (int c = 0; c < 4; c++) begin
      drive(c < 3, 3'b111, {5'd12, 5'd11, 5'd10},
            {32'h33, 32'h22, 32'h11}, er);
      #1;
      n_vec++;
      if (req_ready !== er) begin
        n_err++;
        $display("FAIL hold_ready[%0d]: got %b want %b", c, req_ready, er);
      end
      @(negedge clk);
      e = q.pop_front();
      n_vec++;
      if ({rf_we3, rf_a3, rf_wd3, grant_id, wr_count} !== e) begin
        n_err++;
        $display("FAIL hold_write[%0d]: got %h want %h", c,
                 {rf_we3, rf_a3, rf_wd3, grant_id, wr_count}, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, (c < 2) ? 3'b011 : 3'b000, {5'd9, 5'd9, 5'd9},
            {32'h3, 32'h2222, 32'h1111}, er);
      #1;
      n_vec++;
      if (req_ready !== er) begin
        n_err++;
        $display("FAIL b2b_ready[%0d]: got %b want %b", c, req_ready, er);
      end
      @(negedge clk);
      e = q.pop_front();
      n_vec++;
      if ({rf_we3, rf_a3, rf_wd3, grant_id, wr_count} !== e) begin
        n_err++;
        $display("FAIL b2b_write[%0d]: got %h want %h", c,
                 {rf_we3, rf_a3, rf_wd3, grant_id, wr_count}, e);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      drive($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
            15'($urandom), {$urandom, $urandom, $urandom}, er);
      #1;
      n_vec++;
      if (req_ready !== er) begin
        n_err++;
        $display("FAIL rand_ready[%0d]: got %b want %b", c, req_ready, er);
      end
      @(negedge clk);
      e = q.pop_front();
      n_vec++;
      if ({rf_we3, rf_a3, rf_wd3, grant_id, wr_count} !== e) begin
        n_err++;
        $display("FAIL rand_write[%0d]: got %h want %h", c,
                 {rf_we3, rf_a3, rf_wd3, grant_id, wr_count}, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 3'b111, {5'd4, 5'd5, 5'd6}, {32'h44, 32'h55, 32'h66}, er);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    n_vec++;
    if ({req_ready, rf_we3, rf_a3, rf_wd3, grant_id, wr_count} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_async: got rdy=%b we=%b a=%h wd=%h id=%0d cnt=%h want all 0",
               req_ready, rf_we3, rf_a3, rf_wd3, grant_id, wr_count);
    end
    model_clear();
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) reset = 1'b0;
      drive(1'b0, 3'b111, {5'd4, 5'd5, 5'd6}, {32'h44, 32'h55, 32'h66}, er);
      #1;
      n_vec++;
      if (req_ready !== er) begin
        n_err++;
        $display("FAIL rmid_ready[%0d]: got %b want %b", c, req_ready, er);
      end
      @(negedge clk);
      e = q.pop_front();
      n_vec++;
      if ({rf_we3, rf_a3, rf_wd3, grant_id, wr_count} !== e) begin
        n_err++;
        $display("FAIL rmid_write[%0d]: got %h want %h", c,
                 {rf_we3, rf_a3, rf_wd3, grant_id, wr_count}, e);
      end
    end
  endtask

  task automatic test_wrap();
    while (m_cnt != 16'hFFFF) begin
      drive(1'b0, 3'b001, {5'd0, 5'd0, 5'd7}, {64'd0, 32'(m_cnt)}, er);
      @(negedge clk);
      void'(q.pop_front());
    end
    n_vec++;
    if (wr_count !== 16'hFFFF) begin
      n_err++;
      $display("FAIL wrap_preload: got %h want %h", wr_count, 16'hFFFF);
    end
    drive(1'b0, 3'b100, {5'd31, 5'd0, 5'd0}, {32'hFACE, 64'd0}, er);
    @(negedge clk);
    e = q.pop_front();
    n_vec++;
    if ({rf_we3, rf_a3, rf_wd3, grant_id, wr_count} !== e) begin
      n_err++;
      $display("FAIL wrap_write: got %h want %h",
               {rf_we3, rf_a3, rf_wd3, grant_id, wr_count}, e);
    end
    n_vec++;
    if (wr_count !== 16'h0000) begin
      n_err++;
      $display("FAIL wrap_count: got %h want %h", wr_count, 16'h0000);
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b1;
    hold      = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_x0();
    test_hold();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of write data.
REQ-002 Parameter ADDR_WIDTH, default 5, register address width.
REQ-003 Parameter NREQ, default 3, number of write requesters; legal range 2..4.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 hold  input  1  blocks all grants while high.
REQ-007 req_valid  input  NREQ  per-requester write request.
REQ-008 req_addr  input  NREQ*ADDR_WIDTH  packed destination addresses; requester i in slice i.
REQ-009 req_data  input  NREQ*DATA_WIDTH  packed write data; requester i in slice i.
REQ-010 req_ready  output  NREQ  one-hot (or zero) grant to the requesters; combinational.
REQ-011 rf_a3  output  ADDR_WIDTH  registered write address to the register file.
REQ-012 rf_wd3  output  DATA_WIDTH  registered write data to the register file.
REQ-013 rf_we3  output  1  registered write enable to the register file.
REQ-014 grant_id  output  2  registered index of the requester whose write is on rf_* this cycle.
REQ-015 wr_count  output  16  registered count of committed non-x0 writes.

Function
REQ-016 The block SHALL assert at most one req_ready bit per cycle.
REQ-017 A transfer SHALL occur for requester i when req_valid[i] and req_ready[i] are both 1 at a rising edge.
REQ-018 When hold=1, req_ready SHALL be all zero.
REQ-019 When hold=0, req_ready SHALL grant the first valid requester found searching upward from priority pointer ptr, wrapping from NREQ-1 to 0.
REQ-020 req_ready[i] SHALL never be 1 while req_valid[i]=0.
REQ-021 After a transfer from requester i, ptr SHALL become (i+1) mod NREQ; with no transfer, ptr SHALL hold.
REQ-022 The write stage SHALL have 1-cycle latency: a transfer at edge N drives rf_a3, rf_wd3 and grant_id for the cycle after edge N.
REQ-023 rf_we3 SHALL be 1 for exactly that cycle when the transferred address is non-zero.
REQ-024 A transfer with address 0 SHALL be accepted and consumed with rf_we3=0; wr_count does not increment.
REQ-025 With no transfer at an edge, rf_we3 SHALL be 0 for the next cycle, and rf_a3, rf_wd3 and grant_id SHALL hold their values.
REQ-026 wr_count SHALL increment by 1 for each cycle with rf_we3=1, and wrap from 0xFFFF to 0x0000.
REQ-027 Back-to-back transfers to the same address SHALL be issued in grant order; the later write wins.
REQ-028 A requester that keeps req_valid high with NREQ-1 competitors active SHALL be granted within NREQ cycles.
REQ-029 A requester SHALL NOT be starved by hold=0 traffic from others.
REQ-030 Changes to req_addr or req_data while ready is low SHALL have no effect.

Reset
REQ-031 When reset is asserted, the following SHALL clear immediately, without waiting for clk: ptr=0, rf_we3=0, rf_a3=0, rf_wd3=0, grant_id=0, wr_count=0.
REQ-032 A write that transferred in the cycle reset asserts SHALL be dropped; rf_we3 stays 0.
REQ-033 While reset is high, req_ready SHALL be all zero.
REQ-034 The first grant after reset release SHALL follow ptr=0 priority.

Verification
REQ-035 Single request: req_valid=001, addr=5, data=0xDEADBEEF -> req_ready=001 in that cycle; next cycle rf_we3=1, rf_a3=5, rf_wd3=0xDEADBEEF, grant_id=0, wr_count=1.
REQ-036 Round-robin: req_valid=111 held for 6 cycles -> grants 0,1,2,0,1,2, one per cycle, and rf_we3 high for 6 consecutive cycles.
REQ-037 x0 suppression: requester 1 writes addr 0, data 0x1234 -> req_ready[1]=1; next cycle rf_we3=0 and wr_count unchanged.
REQ-038 Hold: hold=1 with req_valid=111 for 3 cycles -> req_ready=000 and rf_we3=0; after hold drops, first grant goes to ptr.
REQ-039 Reset mid-stream: assert reset asynchronously between edges during continuous traffic -> rf_we3=0 and wr_count=0 before the next edge; after release, first grant goes to requester 0.
REQ-040 Counter wrap: preload traffic to 0xFFFF commits, then one more non-x0 write -> wr_count=0x0000.
